ifft8_iter: RTL and testbench

Iterative 8-point radix-2 inverse FFT. It is the return path for the `fft` block: it accepts 8 complex Q8.8 frequency-domain samples, time-shares one butterfly over 12 cycles, and presents 8 complex Q8.8 time-domain samples, scaled by 1/8. It uses the same write/start/ready handshake and port layout as `fft`, so the two blocks chain directly (`fft` outputs feed `ifft8_iter` inputs).

---
 rtl/ifft8_iter_if.sv | 83 ++++++++
 rtl/ifft8_iter.sv | 217 +++++++++++++++++++++
 tb/tb_ifft8_iter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifft8_iter_if.sv
// ifft8_iter bus: write/start handshake, 8 complex Q8.8 inputs, 8 outputs.
// master drives write/start/inputN_*; slave returns outputN_* and ready.
interface ifft8_iter_if #(
  parameter int W = 16
);
  logic write;
  logic start;
  logic ready;
  logic signed [W-1:0] input0_real;
  logic signed [W-1:0] input1_real;
  logic signed [W-1:0] input2_real;
  logic signed [W-1:0] input3_real;
  logic signed [W-1:0] input4_real;
  logic signed [W-1:0] input5_real;
  logic signed [W-1:0] input6_real;
  logic signed [W-1:0] input7_real;
  logic signed [W-1:0] input0_imag;
  logic signed [W-1:0] input1_imag;
  logic signed [W-1:0] input2_imag;
  logic signed [W-1:0] input3_imag;
  logic signed [W-1:0] input4_imag;
  logic signed [W-1:0] input5_imag;
  logic signed [W-1:0] input6_imag;
  logic signed [W-1:0] input7_imag;
  logic signed [W-1:0] output0_real;
  logic signed [W-1:0] output1_real;
  logic signed [W-1:0] output2_real;
  logic signed [W-1:0] output3_real;
  logic signed [W-1:0] output4_real;
  logic signed [W-1:0] output5_real;
  logic signed [W-1:0] output6_real;
  logic signed [W-1:0] output7_real;
  logic signed [W-1:0] output0_imag;
  logic signed [W-1:0] output1_imag;
  logic signed [W-1:0] output2_imag;
  logic signed [W-1:0] output3_imag;
  logic signed [W-1:0] output4_imag;
  logic signed [W-1:0] output5_imag;
  logic signed [W-1:0] output6_imag;
  logic signed [W-1:0] output7_imag;

  modport master (
    output write, start,
    output input0_real, input1_real,
    output input2_real, input3_real,
    output input4_real, input5_real,
    output input6_real, input7_real,
    output input0_imag, input1_imag,
    output input2_imag, input3_imag,
    output input4_imag, input5_imag,
    output input6_imag, input7_imag,
    input ready,
    input output0_real, output1_real,
    input output2_real, output3_real,
    input output4_real, output5_real,
    input output6_real, output7_real,
    input output0_imag, output1_imag,
    input output2_imag, output3_imag,
    input output4_imag, output5_imag,
    input output6_imag, output7_imag
  );

  modport slave (
    input write, start,
    input input0_real, input1_real,
    input input2_real, input3_real,
    input input4_real, input5_real,
    input input6_real, input7_real,
    input input0_imag, input1_imag,
    input input2_imag, input3_imag,
    input input4_imag, input5_imag,
    input input6_imag, input7_imag,
    output ready,
    output output0_real, output1_real,
    output output2_real, output3_real,
    output output4_real, output5_real,
    output output6_real, output7_real,
    output output0_imag, output1_imag,
    output output2_imag, output3_imag,
    output output4_imag, output5_imag,
    output output6_imag, output7_imag
  );
endinterface

// File: rtl/ifft8_iter.sv
// Iterative 8-point radix-2 IFFT, one butterfly/cycle, output scaled 1/8.
// Ports: clk, rst (sync, active-low), bus (ifft8_iter_if.slave).
module ifft8_iter #(
  parameter int W   = 16,
  parameter int C45 = 181
) (
  input logic        clk,
  input logic        rst,
  ifft8_iter_if.slave bus
);
  localparam int PW = 2 * W;
  localparam int TW = W + 2;
  localparam int SW = W + 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic signed [W-1:0] smp_t;

  state_t state, state_n;
  logic [1:0] s, b;
  logic load, go, bfly, copy;
  logic [2:0] top, bot;
  logic [1:0] k;
  smp_t wr, wi;
  logic signed [PW-1:0] pr, pi;
  logic signed [TW-1:0] tr, ti;
  smp_t ar_n, ai_n, br_n, bi_n;

  smp_t in_re [8];
  smp_t in_im [8];
  // store keeps the written spectrum so a bare start in DONE
  // repeats the last transform; work is the butterfly bank
  smp_t store_re [8];
  smp_t store_im [8];
  smp_t work_re [8];
  smp_t work_im [8];
  smp_t out_re [8];
  smp_t out_im [8];

  function automatic logic [2:0] rev3(input logic [2:0] x);
    return {x[0], x[1], x[2]};
  endfunction

  assign in_re[0] = bus.input0_real;
  assign in_re[1] = bus.input1_real;
  assign in_re[2] = bus.input2_real;
  assign in_re[3] = bus.input3_real;
  assign in_re[4] = bus.input4_real;
  assign in_re[5] = bus.input5_real;
  assign in_re[6] = bus.input6_real;
  assign in_re[7] = bus.input7_real;
  assign in_im[0] = bus.input0_imag;
  assign in_im[1] = bus.input1_imag;
  assign in_im[2] = bus.input2_imag;
  assign in_im[3] = bus.input3_imag;
  assign in_im[4] = bus.input4_imag;
  assign in_im[5] = bus.input5_imag;
  assign in_im[6] = bus.input6_imag;
  assign in_im[7] = bus.input7_imag;

  assign bus.output0_real = out_re[0];
  assign bus.output1_real = out_re[1];
  assign bus.output2_real = out_re[2];
  assign bus.output3_real = out_re[3];
  assign bus.output4_real = out_re[4];
  assign bus.output5_real = out_re[5];
  assign bus.output6_real = out_re[6];
  assign bus.output7_real = out_re[7];
  assign bus.output0_imag = out_im[0];
  assign bus.output1_imag = out_im[1];
  assign bus.output2_imag = out_im[2];
  assign bus.output3_imag = out_im[3];
  assign bus.output4_imag = out_im[4];
  assign bus.output5_imag = out_im[5];
  assign bus.output6_imag = out_im[6];
  assign bus.output7_imag = out_im[7];

  assign bus.ready = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // s == 3 is the copy-out cycle after the twelfth butterfly
  always_comb begin
    state_n = state;
    load    = 1'b0;
    go      = 1'b0;
    bfly    = 1'b0;
    copy    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        load = bus.write;
        go   = bus.start;
        if (bus.start)      state_n = RUN;
        else if (bus.write) state_n = IDLE;
      end
      RUN: begin
        if (s == 2'd3) begin
          copy    = 1'b1;
          state_n = DONE;
        end else begin
          bfly = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    top = 3'd0;
    bot = 3'd0;
    k   = 2'd0;
    unique case (s)
      2'd0: begin
        top = {b, 1'b0};
        bot = {b, 1'b1};
      end
      2'd1: begin
        top = {b[1], 1'b0, b[0]};
        bot = {b[1], 1'b1, b[0]};
        k   = {b[0], 1'b0};
      end
      2'd2: begin
        top = {1'b0, b};
        bot = {1'b1, b};
        k   = b;
      end
      default: ;
    endcase
  end

  // W8^-k = e^{+j*pi*k/4}
  always_comb begin
    wr = smp_t'(256);
    wi = '0;
    unique case (k)
      2'd1: begin
        wr = smp_t'(C45);
        wi = smp_t'(C45);
      end
      2'd2: begin
        wr = '0;
        wi = smp_t'(256);
      end
      2'd3: begin
        wr = smp_t'(-C45);
        wi = smp_t'(C45);
      end
      default: ;
    endcase
  end

  assign pr = PW'(work_re[bot]) * PW'(wr)
            - PW'(work_im[bot]) * PW'(wi);
  assign pi = PW'(work_re[bot]) * PW'(wi)
            + PW'(work_im[bot]) * PW'(wr);
  assign tr = TW'(pr >>> 8);
  assign ti = TW'(pi >>> 8);

  assign ar_n = W'((SW'(work_re[top]) + SW'(tr)) >>> 1);
  assign ai_n = W'((SW'(work_im[top]) + SW'(ti)) >>> 1);
  assign br_n = W'((SW'(work_re[top]) - SW'(tr)) >>> 1);
  assign bi_n = W'((SW'(work_im[top]) - SW'(ti)) >>> 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      s <= 2'd0;
      b <= 2'd0;
      for (int i = 0; i < 8; i++) begin
        store_re[i] <= '0;
        store_im[i] <= '0;
        work_re[i]  <= '0;
        work_im[i]  <= '0;
        out_re[i]   <= '0;
        out_im[i]   <= '0;
      end
    end else begin
      if (load) begin
        for (int i = 0; i < 8; i++) begin
          store_re[rev3(3'(i))] <= in_re[i];
          store_im[rev3(3'(i))] <= in_im[i];
        end
      end
      if (go) begin
        s <= 2'd0;
        b <= 2'd0;
        for (int i = 0; i < 8; i++) begin
          work_re[rev3(3'(i))] <= load ? in_re[i]
                                : store_re[rev3(3'(i))];
          work_im[rev3(3'(i))] <= load ? in_im[i]
                                : store_im[rev3(3'(i))];
        end
      end
      if (bfly) begin
        work_re[top] <= ar_n;
        work_im[top] <= ai_n;
        work_re[bot] <= br_n;
        work_im[bot] <= bi_n;
        {s, b} <= {s, b} + 4'd1;
      end
      if (copy) begin
        s <= 2'd0;
        b <= 2'd0;
        for (int i = 0; i < 8; i++) begin
          out_re[i] <= work_re[i];
          out_im[i] <= work_im[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_ifft8_iter.sv
// Bench for ifft8_iter: vector table + scoreboard, reset/abuse/round trip.
// Drives bus.master-side signals, checks outputs at the falling edge.
module tb_ifft8_iter;
  typedef int vec_t [8];

  typedef struct {
    string name;
    vec_t  xr;
    vec_t  xi;
    vec_t  er;
    vec_t  ei;
  } rec_t;

  typedef struct {
    string name;
    vec_t  er;
    vec_t  ei;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t cur_r, cur_i, last_r, last_i;
  vec_t zero = '{0, 0, 0, 0, 0, 0, 0, 0};

  ifft8_iter_if #(.W(16)) bus ();

  ifft8_iter #(.W(16), .C45(181)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int sx16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  // bit-accurate reference of the butterfly schedule
  function automatic void model(input vec_t xr, input vec_t xi,
                                output vec_t yr, output vec_t yi);
    int br[8];
    int bi[8];
    int wre[4] = '{256, 181, 0, -181};
    int wim[4] = '{0, 181, 256, 181};
    int tp[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int tk[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    for (int n = 0; n < 8; n++) begin
      int r;
      r = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      br[r] = xr[n];
      bi[r] = xi[n];
    end
    for (int j = 0; j < 12; j++) begin
      int a, c, q, tr, ti, ar, ai;
      a = tp[j];
      c = a + (1 << (j / 4));
      q = tk[j];
      tr = (br[c] * wre[q] - bi[c] * wim[q]) >>> 8;
      ti = (br[c] * wim[q] + bi[c] * wre[q]) >>> 8;
      ar = sx16((br[a] + tr) >>> 1);
      ai = sx16((bi[a] + ti) >>> 1);
      br[c] = sx16((br[a] - tr) >>> 1);
      bi[c] = sx16((bi[a] - ti) >>> 1);
      br[a] = ar;
      bi[a] = ai;
    end
    for (int n = 0; n < 8; n++) begin
      yr[n] = br[n];
      yi[n] = bi[n];
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input int act,
                         input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d +/-%0d",
               nm, act, exp, tol);
    end
  endtask

  task automatic drive(input vec_t r, input vec_t i);
    cur_r = r;
    cur_i = i;
    bus.input0_real = 16'(r[0]);
    bus.input1_real = 16'(r[1]);
    bus.input2_real = 16'(r[2]);
    bus.input3_real = 16'(r[3]);
    bus.input4_real = 16'(r[4]);
    bus.input5_real = 16'(r[5]);
    bus.input6_real = 16'(r[6]);
    bus.input7_real = 16'(r[7]);
    bus.input0_imag = 16'(i[0]);
    bus.input1_imag = 16'(i[1]);
    bus.input2_imag = 16'(i[2]);
    bus.input3_imag = 16'(i[3]);
    bus.input4_imag = 16'(i[4]);
    bus.input5_imag = 16'(i[5]);
    bus.input6_imag = 16'(i[6]);
    bus.input7_imag = 16'(i[7]);
  endtask

  task automatic read_out(output vec_t r, output vec_t i);
    r[0] = int'(bus.output0_real);
    r[1] = int'(bus.output1_real);
    r[2] = int'(bus.output2_real);
    r[3] = int'(bus.output3_real);
    r[4] = int'(bus.output4_real);
    r[5] = int'(bus.output5_real);
    r[6] = int'(bus.output6_real);
    r[7] = int'(bus.output7_real);
    i[0] = int'(bus.output0_imag);
    i[1] = int'(bus.output1_imag);
    i[2] = int'(bus.output2_imag);
    i[3] = int'(bus.output3_imag);
    i[4] = int'(bus.output4_imag);
    i[5] = int'(bus.output5_imag);
    i[6] = int'(bus.output6_imag);
    i[7] = int'(bus.output7_imag);
  endtask

  task automatic push(input string nm, input vec_t er, input vec_t ei);
    exp_t e;
    e.name = nm;
    e.er = er;
    e.ei = ei;
    sb.push_back(e);
  endtask

  task automatic push_model(input string nm);
    vec_t er, ei;
    model(last_r, last_i, er, ei);
    push(nm, er, ei);
  endtask

  // one-cycle pulse, called and returning at a falling edge
  task automatic kick(input bit w, input bit s);
    bus.write = w;
    bus.start = s;
    if (w) begin
      last_r = cur_r;
      last_i = cur_i;
    end
    @(posedge clk);
    @(negedge clk);
    bus.write = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic compare(input string nm);
    exp_t e;
    vec_t ar, ai;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no expected entry", nm);
      return;
    end
    e = sb.pop_front();
    read_out(ar, ai);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("%s x%0d re", e.name, n), ar[n], e.er[n]);
      chk($sformatf("%s x%0d im", e.name, n), ai[n], e.ei[n]);
    end
  endtask

  // abuse != 0 pulses write+start with alt data during RUN
  task automatic wait_done(input string nm, input int abuse,
                           input vec_t alt);
    int n = 0;
    chk({nm, " ready low after start"}, int'(bus.ready), 0);
    while (bus.ready !== 1'b1 && n < 40) begin
      if (abuse != 0 && (n == 2 || n == 5)) begin
        drive(alt, alt);
        bus.write = 1'b1;
        bus.start = 1'b1;
      end else begin
        bus.write = 1'b0;
        bus.start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bus.write = 1'b0;
    bus.start = 1'b0;
    chk({nm, " latency"}, n, 13);
    compare(nm);
  endtask

  task automatic check_zero(input string nm);
    vec_t ar, ai;
    read_out(ar, ai);
    chk({nm, " ready"}, int'(bus.ready), 0);
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("%s x%0d re", nm, n), ar[n], 0);
      chk($sformatf("%s x%0d im", nm, n), ai[n], 0);
    end
  endtask

  rec_t tbl[5];

  initial begin
    vec_t rr, ri, alt, ar, ai;
    int   hi;
    rst = 1'b0;
    bus.write = 1'b0;
    bus.start = 1'b0;
    drive(zero, zero);
    last_r = zero;
    last_i = zero;

    tbl[0].name = "impulse";
    tbl[0].xr = '{2048, 0, 0, 0, 0, 0, 0, 0};
    tbl[0].xi = zero;
    tbl[0].er = '{256, 256, 256, 256, 256, 256, 256, 256};
    tbl[0].ei = zero;
    tbl[1].name = "flat";
    tbl[1].xr = '{32, 32, 32, 32, 32, 32, 32, 32};
    tbl[1].xi = zero;
    tbl[1].er = '{32, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].ei = zero;
    tbl[2].name = "tone";
    tbl[2].xr = '{0, 2048, 0, 0, 0, 0, 0, 0};
    tbl[2].xi = zero;
    tbl[2].er = '{256, 181, 0, -181, -256, -181, 0, 181};
    tbl[2].ei = '{0, 181, 256, 181, 0, -181, -256, -181};
    for (int j = 3; j < 5; j++) begin
      tbl[j].name = $sformatf("rand%0d", j);
      for (int n = 0; n < 8; n++) begin
        tbl[j].xr[n] = int'($urandom_range(0, 8000)) - 4000;
        tbl[j].xi[n] = int'($urandom_range(0, 8000)) - 4000;
      end
      model(tbl[j].xr, tbl[j].xi, tbl[j].er, tbl[j].ei);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int j = 0; j < 5; j++) begin
      drive(tbl[j].xr, tbl[j].xi);
      push(tbl[j].name, tbl[j].er, tbl[j].ei);
      kick(1'b1, 1'b1);
      wait_done(tbl[j].name, 0, zero);
    end

    // reset in the middle of RUN
    drive(tbl[2].xr, tbl[2].xi);
    kick(1'b1, 1'b1);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("midrun reset");
    rst = 1'b1;
    hi = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready === 1'b1) hi++;
    end
    chk("no ready after abort", hi, 0);
    drive(tbl[2].xr, tbl[2].xi);
    kick(1'b1, 1'b1);
    push_model("after abort");
    wait_done("after abort", 0, zero);

    // write/start during RUN must be ignored
    drive(tbl[3].xr, tbl[3].xi);
    kick(1'b1, 1'b1);
    push_model("abuse");
    alt = tbl[1].xr;
    wait_done("abuse", 1, alt);

    // bare start in DONE reruns the stored spectrum back-to-back
    kick(1'b0, 1'b1);
    push_model("restart");
    wait_done("restart", 0, zero);

    // round trip: ideal forward fft of a ramp, scaled 1/8
    for (int q = 0; q < 8; q++) begin
      real sr, si, ang;
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 8; n++) begin
        ang = -2.0 * 3.14159265358979 * q * n / 8.0;
        sr += 256.0 * n * $cos(ang);
        si += 256.0 * n * $sin(ang);
      end
      rr[q] = int'(sr / 8.0);
      ri[q] = int'(si / 8.0);
    end
    drive(rr, ri);
    kick(1'b1, 1'b1);
    push_model("round trip");
    wait_done("round trip", 0, zero);
    read_out(ar, ai);
    for (int n = 0; n < 8; n++) begin
      chk_tol($sformatf("rt x%0d re", n), 8 * ar[n], 256 * n, 8);
      chk_tol($sformatf("rt x%0d im", n), 8 * ai[n], 0, 8);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
